fmult_seq: RTL
==============

FMULT_SEQ -- requirements
Module: fmult_seq

Interface
REQ-001 SHALL have a single clock `clk` and a synchronous, active-high reset `reset`.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request one 8-term product sequence; sampled only in IDLE.
REQ-005 B  input  96  B6..B1 zero coefficients, 16-bit two's complement each, B1 in [15:0].
REQ-006 DQ  input  66  DQ6..DQ1 float operands, 11 bits each {sign, exp[3:0], mant[5:0]}, DQ1 in [10:0].
REQ-007 A  input  32  A2..A1 pole coefficients, 16-bit two's complement, A1 in [15:0].
REQ-008 SR  input  22  SR2..SR1 float operands, same format as DQ, SR1 in [10:0].
REQ-009 W  output  16  partial product to the downstream accumulator (two's complement).
REQ-010 clear  output  1  one-cycle accumulator clear, issued at sequence start.
REQ-011 busy  output  1  high from the cycle after start is accepted through the done cycle.
REQ-012 done  output  1  one-cycle pulse when the sequence completes.

Function
REQ-013 States: IDLE, CLR, TERM, FLUSH. Transitions:
  - IDLE -> CLR on start.
  - CLR -> TERM.
  - TERM stays in TERM while the 3-bit term index k < 7, then -> FLUSH.
  - FLUSH -> IDLE.
REQ-014 The cycle start is accepted SHALL latch all of B, DQ, A and SR. Input changes during busy SHALL NOT affect results.
REQ-015 start asserted while busy SHALL be ignored, with no queuing.
REQ-016 Cycle timing relative to acceptance edge n:
  - n+1: clear=1, W=0.
  - n+2..n+9: W = product of term k = 0..7.
  - n+10: W=0, done=1.
REQ-017 Term order SHALL be: B1*DQ1, B2*DQ2, B3*DQ3, B4*DQ4, B5*DQ5, B6*DQ6, A1*SR1, A2*SR2.
REQ-018 All outputs SHALL be registered. A single shared multiplier SHALL be used, with the operand mux indexed by k.
REQ-019 Coefficient conversion for coefficient C:
  - S = C[15].
  - MAG = (S ? -C : C) >> 2, masked to 13 bits.
  - EXP = 0 if MAG = 0, else floor(log2 MAG) + 1 (range 0..13).
  - MANT = 32 if MAG = 0, else (MAG << 6) >> EXP (6 bits).
REQ-020 Product computation:
  - WS = S xor opS.
  - WEXP = EXP + opEXP (5 bits, range 0..28).
  - WMANT = (opMANT*MANT + 48) >> 4 (8 bits).
REQ-021 Magnitude: WMAG = (WMANT << 7) >> (26 - WEXP) when WEXP <= 26. Otherwise WMAG = ((WMANT << 7) << (WEXP - 26)) masked to 15 bits.
REQ-022 W = WS ? (-WMAG mod 2^16) : WMAG. A zero magnitude with WS=1 SHALL yield 0x0000.
REQ-023 In IDLE: W=0, clear=0, done=0, busy=0.
REQ-024 start arriving in the same cycle as the done pulse SHALL be ignored. The earliest re-acceptance is the following cycle.

Reset
REQ-025 Synchronous reset SHALL force:
  - state = IDLE, k = 0, W = 0.
  - clear = 0, busy = 0, done = 0.
  - latched operands = 0.
REQ-026 Reset mid-sequence SHALL abort the sequence with no done pulse. start is ignored while reset is high.

Configuration
REQ-027 Macro FMULT_SEQ_SCAN_EN, when defined, SHALL add:
  - inputs scan_in0..scan_in4, scan_enable, test_mode (1 bit each);
  - outputs scan_out0..scan_out4, tied 0 in RTL.
  Functional behaviour SHALL be identical with or without it.
REQ-028 Without FMULT_SEQ_SCAN_EN these ports SHALL be absent.

Verification
REQ-029 All operands 0, start pulse:
  - clear=1 at n+1;
  - W=0x0000 for 8 cycles;
  - done=1 at n+10.
REQ-030 B1=0x4000, DQ1=0x060, all others 0 -> W=0x0002 at n+2, 0x0000 elsewhere.
REQ-031 Sign handling with the REQ-030 operands:
  - B1=0xC000, DQ1=0x060 -> W=0xFFFE;
  - B1=0xC000, DQ1=0x460 -> W=0x0002.
REQ-032 A2=0x4000, SR2=0x3E0 (WEXP=28, left-shift path) -> W=0x0600 at n+9.
REQ-033 Control corner cases:
  - start held high continuously -> sequences start every 11 cycles, with no start accepted during busy;
  - operands changed at n+3 -> the remaining terms are unaffected.
REQ-034 reset asserted at n+5 -> next cycle all outputs 0 and IDLE, no done pulse; a start afterwards restarts cleanly from CLR.

Source files
------------

// File: rtl/fmult_seq.sv
// ---------------------------------------------------------------------------
// fmult_seq
//   Sequential 8-term multiplier. It walks the six zero terms (B1*DQ1 ..
//   B6*DQ6) and then the two pole terms (A1*SR1, A2*SR2) through one shared
//   floating-point style multiplier. It streams each 16-bit partial product
//   to a downstream accumulator, one product per cycle.
//
//   Ports
//     clk    : rising-edge clock for all state
//     reset  : synchronous, active-high reset
//     start  : request a sequence (sampled in IDLE only, ignored on the
//              done cycle)
//     B      : B6..B1 16-bit two's complement coefficients, B1 in [15:0]
//     DQ     : DQ6..DQ1 11-bit {sign, exp[3:0], mant[5:0]}, DQ1 in [10:0]
//     A      : A2..A1 16-bit two's complement coefficients, A1 in [15:0]
//     SR     : SR2..SR1 11-bit float operands, SR1 in [10:0]
//     W      : registered partial product (two's complement)
//     clear  : one-cycle accumulator clear at sequence start
//     busy   : high from the cycle after acceptance through the done cycle
//     done   : one-cycle completion pulse
//
//   Optional build macro FMULT_SEQ_SCAN_EN adds the scan_in0..4,
//   scan_enable and test_mode inputs and the scan_out0..4 outputs. The
//   scan outputs are tied low, and the function is unchanged.
// ---------------------------------------------------------------------------
module fmult_seq (
    input  logic        clk,
    input  logic        reset,
`ifdef FMULT_SEQ_SCAN_EN
    input  logic        scan_in0,
    input  logic        scan_in1,
    input  logic        scan_in2,
    input  logic        scan_in3,
    input  logic        scan_in4,
    input  logic        scan_enable,
    input  logic        test_mode,
    output logic        scan_out0,
    output logic        scan_out1,
    output logic        scan_out2,
    output logic        scan_out3,
    output logic        scan_out4,
`endif
    input  logic        start,
    input  logic [95:0] B,
    input  logic [65:0] DQ,
    input  logic [31:0] A,
    input  logic [21:0] SR,
    output logic [15:0] W,
    output logic        clear,
    output logic        busy,
    output logic        done
);

`ifdef FMULT_SEQ_SCAN_EN
    // Scan chain is stitched in later; the functional RTL only ties it off.
    logic unused_scan;
    assign unused_scan = ^{scan_in0, scan_in1, scan_in2, scan_in3, scan_in4,
                           scan_enable, test_mode};
    assign scan_out0 = 1'b0;
    assign scan_out1 = 1'b0;
    assign scan_out2 = 1'b0;
    assign scan_out3 = 1'b0;
    assign scan_out4 = 1'b0;
`endif

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CLR   = 2'd1;
    localparam logic [1:0] ST_TERM  = 2'd2;
    localparam logic [1:0] ST_FLUSH = 2'd3;

    logic [1:0]  state_reg;
    logic [2:0]  k_reg;
    logic [15:0] w_reg;
    logic        clear_reg;
    logic        busy_reg;
    logic        done_reg;

    // Operand slots 0..7 are stored in term order. This lets one k-indexed
    // mux feed the shared multiplier.
    logic [15:0] coef_in  [0:7];
    logic [10:0] opnd_in  [0:7];
    logic [15:0] coef_reg [0:7];
    logic [10:0] opnd_reg [0:7];

    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_zero_terms
            assign coef_in[gi] = B[16*gi +: 16];
            assign opnd_in[gi] = DQ[11*gi +: 11];
        end
        for (gi = 0; gi < 2; gi++) begin : g_pole_terms
            assign coef_in[6+gi] = A[16*gi +: 16];
            assign opnd_in[6+gi] = SR[11*gi +: 11];
        end
    endgenerate

    // ---------------- shared multiplier datapath ----------------
    logic [15:0] coef_sel;
    logic [10:0] opnd_sel;
    logic        coef_sign;
    logic [15:0] coef_abs;
    logic [12:0] coef_mag;
    logic [3:0]  coef_exp;
    logic [5:0]  coef_mant;
    logic [11:0] prod;
    logic [7:0]  w_mant;
    logic [4:0]  w_exp;
    logic [14:0] w_base;
    logic [14:0] w_mag;
    logic [15:0] w_term;

    assign coef_sel = coef_reg[k_reg];
    assign opnd_sel = opnd_reg[k_reg];

    always_comb begin
        coef_sign = coef_sel[15];
        coef_abs  = coef_sign ? (16'd0 - coef_sel) : coef_sel;
        // -0x8000 stays 0x8000, so its magnitude masks to zero here.
        coef_mag  = 13'(coef_abs >> 2);

        // The exponent is the bit length of the magnitude.
        coef_exp = 4'd0;
        for (int i = 0; i < 13; i++) begin
            if (coef_mag[i]) begin
                coef_exp = 4'(i + 1);
            end
        end
        // Normalise to the six bits at and below the leading one.
        coef_mant = (coef_mag == 13'd0) ? 6'd32
                                        : 6'({coef_mag, 6'd0} >> coef_exp);

        prod   = {6'd0, opnd_sel[5:0]} * {6'd0, coef_mant};
        w_mant = 8'((prod + 12'd48) >> 4);
        w_exp  = 5'(coef_exp) + 5'(opnd_sel[9:6]);
        w_base = {w_mant, 7'd0};
        // Exponents above 26 shift left; overflow falls off the 15-bit result.
        if (w_exp <= 5'd26) begin
            w_mag = w_base >> (5'd26 - w_exp);
        end else begin
            w_mag = w_base << (w_exp - 5'd26);
        end
        // Zero magnitude negates to zero, so a negative zero never appears.
        w_term = (coef_sign ^ opnd_sel[10]) ? (16'd0 - {1'b0, w_mag})
                                            : {1'b0, w_mag};
    end

    // ---------------- sequencer ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            k_reg     <= 3'd0;
            w_reg     <= 16'd0;
            clear_reg <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                coef_reg[i] <= 16'd0;
                opnd_reg[i] <= 11'd0;
            end
        end else begin
            clear_reg <= 1'b0;
            done_reg  <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    w_reg <= 16'd0;
                    // The done pulse is shown while already in IDLE; a start
                    // on that cycle must not be taken.
                    if (start && !done_reg) begin
                        for (int i = 0; i < 8; i++) begin
                            coef_reg[i] <= coef_in[i];
                            opnd_reg[i] <= opnd_in[i];
                        end
                        k_reg     <= 3'd0;
                        clear_reg <= 1'b1;
                        busy_reg  <= 1'b1;
                        state_reg <= ST_CLR;
                    end else begin
                        busy_reg <= 1'b0;
                    end
                end
                ST_CLR: begin
                    w_reg     <= w_term;
                    k_reg     <= k_reg + 3'd1;
                    state_reg <= ST_TERM;
                end
                ST_TERM: begin
                    w_reg <= w_term;
                    k_reg <= k_reg + 3'd1;      // wraps back to 0 after term 7
                    if (k_reg == 3'd7) begin
                        state_reg <= ST_FLUSH;
                    end
                end
                default: begin                  // ST_FLUSH
                    w_reg     <= 16'd0;
                    done_reg  <= 1'b1;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign W     = w_reg;
    assign clear = clear_reg;
    assign busy  = busy_reg;
    assign done  = done_reg;

endmodule
